// File: rtl/lvds_tx_pixel_packer_if.sv
// -----------------------------------------------------------------------------
// lvds_tx_pixel_packer_if
//   Bundles the pixel-source handshake, the control strobes and the four
//   serializer lane words of lvds_tx_pixel_packer.
//
//   en            run enable (low holds timing at 0 and blanks the lanes)
//   pix_data      {R[7:0],G[7:0],B[7:0]} from the frame source
//   pix_valid     source has a pixel
//   pix_ready     packer takes the pixel this cycle
//   clr_underflow clears the sticky underflow flag
//   data0..data3  7-bit lane words, bit 0 transmitted first
//   sof           one-cycle pulse with the first active pixel of a frame
//   underflow     sticky source-underflow flag
//
//   slave  : the packer side
//   master : the frame source / controller side
// -----------------------------------------------------------------------------
interface lvds_tx_pixel_packer_if;
    logic        en;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        clr_underflow;
    logic [6:0]  data0;
    logic [6:0]  data1;
    logic [6:0]  data2;
    logic [6:0]  data3;
    logic        sof;
    logic        underflow;

    modport slave (
        input  en, pix_data, pix_valid, clr_underflow,
        output pix_ready, data0, data1, data2, data3, sof, underflow
    );

    modport master (
        output en, pix_data, pix_valid, clr_underflow,
        input  pix_ready, data0, data1, data2, data3, sof, underflow
    );
endinterface

// File: rtl/lvds_tx_pixel_packer.sv
// -----------------------------------------------------------------------------
// lvds_tx_pixel_packer
//   Display timing generator and RGB888 -> 4x7-bit lane packer feeding the
//   7:1 LVDS serializer. Runs entirely in the pixel clock domain.
//
//   sclk   pixel clock (same clock as the serializer parallel side)
//   reset  synchronous, active-high
//   bus    lvds_tx_pixel_packer_if.slave:
//            in : en, pix_data, pix_valid, clr_underflow
//            out: pix_ready (combinational), data0..data3, sof, underflow
//                 (all registered, one cycle after the pixel is accepted)
// -----------------------------------------------------------------------------
module lvds_tx_pixel_packer #(
    parameter int   H_ACTIVE  = 1920,
    parameter int   H_FP      = 88,
    parameter int   H_SYNC    = 44,
    parameter int   H_BP      = 148,
    parameter int   V_ACTIVE  = 1080,
    parameter int   V_FP      = 4,
    parameter int   V_SYNC    = 5,
    parameter int   V_BP      = 36,
    parameter logic SYNC_ACT  = 1'b0,
    parameter bit   MAP_JEIDA = 1'b0
) (
    input  logic                   sclk,
    input  logic                   reset,
    lvds_tx_pixel_packer_if.slave  bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);

    localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);

    // Sync windows as half-open integer ranges so a zero back porch cannot
    // overflow the counter width.
    localparam int HS_BEG = H_ACTIVE + H_FP;
    localparam int HS_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG = V_ACTIVE + V_FP;
    localparam int VS_END = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [6:0] BLANK_D2 = {1'b0, ~SYNC_ACT, ~SYNC_ACT, 4'b0000};

    // Lane packing. Returns {data3, data2, data1, data0}.
    function automatic logic [27:0] pack_lanes(
        input logic [23:0] rgb,
        input logic        de,
        input logic        vs,
        input logic        hs
    );
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [6:0] d0;
        logic [6:0] d1;
        logic [6:0] d2;
        logic [6:0] d3;
        r = rgb[23:16];
        g = rgb[15:8];
        b = rgb[7:0];
        if (MAP_JEIDA) begin
            d0 = {g[2], r[7:2]};
            d1 = {b[3:2], g[7:3]};
            d2 = {de, vs, hs, b[7:4]};
            d3 = {1'b0, b[1:0], g[1:0], r[1:0]};
        end else begin
            d0 = {g[0], r[5:0]};
            d1 = {b[1:0], g[5:1]};
            d2 = {de, vs, hs, b[5:2]};
            d3 = {1'b0, b[7:6], g[7:6], r[7:6]};
        end
        return {d3, d2, d1, d0};
    endfunction

    logic [HC_W-1:0] r_h_cnt;
    logic [VC_W-1:0] r_v_cnt;

    logic            w_active;
    logic            w_hs;
    logic            w_vs;
    logic            w_first;
    logic [23:0]     w_rgb;
    logic [27:0]     w_lanes;

    logic [6:0]      r_data0_p1;
    logic [6:0]      r_data1_p1;
    logic [6:0]      r_data2_p1;
    logic [6:0]      r_data3_p1;
    logic            r_sof_p1;
    logic            r_underflow;

    // ---- stage p0: timing counters and pixel selection ----
    always_ff @(posedge sclk) begin
        if (reset || !bus.en) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign w_active = (int'(r_h_cnt) < H_ACTIVE) && (int'(r_v_cnt) < V_ACTIVE);
    assign w_hs     = ((int'(r_h_cnt) >= HS_BEG) && (int'(r_h_cnt) < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
    assign w_vs     = ((int'(r_v_cnt) >= VS_BEG) && (int'(r_v_cnt) < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
    assign w_first  = (r_h_cnt == '0) && (r_v_cnt == '0);

    // Counters sit at 0 during reset, which is an active position; masking
    // with reset keeps the source from seeing a transfer that is not taken.
    assign bus.pix_ready = bus.en && !reset && w_active;

    // Missing source data becomes a black pixel rather than stalling timing.
    assign w_rgb   = (w_active && bus.pix_valid) ? bus.pix_data : 24'h0;
    assign w_lanes = pack_lanes(w_rgb, w_active, w_vs, w_hs);

    // ---- stage p1: registered lane words and strobes ----
    always_ff @(posedge sclk) begin
        if (reset || !bus.en) begin
            r_data0_p1 <= 7'd0;
            r_data1_p1 <= 7'd0;
            r_data2_p1 <= BLANK_D2;
            r_data3_p1 <= 7'd0;
            r_sof_p1   <= 1'b0;
        end else begin
            r_data0_p1 <= w_lanes[6:0];
            r_data1_p1 <= w_lanes[13:7];
            r_data2_p1 <= w_lanes[20:14];
            r_data3_p1 <= w_lanes[27:21];
            r_sof_p1   <= w_first;
        end
    end

    // Clear takes priority over a coincident underflow event.
    always_ff @(posedge sclk) begin
        if (reset || bus.clr_underflow) begin
            r_underflow <= 1'b0;
        end else if (bus.en && w_active && !bus.pix_valid) begin
            r_underflow <= 1'b1;
        end
    end

    assign bus.data0     = r_data0_p1;
    assign bus.data1     = r_data1_p1;
    assign bus.data2     = r_data2_p1;
    assign bus.data3     = r_data3_p1;
    assign bus.sof       = r_sof_p1;
    assign bus.underflow = r_underflow;

endmodule
